hyperbus_cfg_shadow_regs: RTL and testbench

Next-generation HyperBus configuration register file with a double-buffered (shadow/active) layout. Register-bus writes always land in a shadow copy and never stall. A commit FSM transfers shadow to active only when no HyperBus transfer is in flight, and only if the chip address ranges pass validation. The block sits between the register bus demux and the hyperbus controller; its `cfg_o` and `chip_rules_o` drive the PHYs and the chip address decoder.

---
 rtl/hyperbus_cfg_shadow_regs.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_hyperbus_cfg_shadow_regs.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_cfg_shadow_regs.sv
// hyperbus_cfg_shadow_regs
//   Double-buffered HyperBus configuration register file. Register-bus writes
//   land in a shadow copy and never stall. A small commit FSM copies the shadow
//   into the active copy only while no HyperBus transfer is in flight, and only
//   if the chip address ranges are well formed and non-overlapping.
//
// Ports
//   clk_i          : clock
//   rst_i          : asynchronous, active-high reset
//   reg_req_i      : register request (addr, write, wdata, wstrb, valid)
//   reg_rsp_o      : register response, combinational, ready always 1
//   cfg_o          : active configuration towards the PHYs
//   chip_rules_o   : active chip address rules towards the address decoder
//   trans_active_i : a HyperBus transfer is in progress
//   cfg_update_o   : one-cycle pulse when the active copy changes

package hyperbus_pkg;

  typedef struct packed {
    logic       polarity;
    logic [1:0] cycle_idx;
  } rwds_sample_t;

  typedef struct packed {
    logic [3:0]   t_latency_access;
    logic         en_latency_additional;
    logic [15:0]  t_burst_max;
    logic [3:0]   t_read_write_recovery;
    logic [3:0]   t_rx_clk_delay;
    logic [3:0]   t_tx_clk_delay;
    logic [4:0]   address_mask_msb;
    logic         address_space;
    logic         phys_in_use;
    logic         which_phy;
    logic [3:0]   t_csh_cycles;
    rwds_sample_t rwds_sample;
  } hyper_cfg_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;

endpackage

module hyperbus_cfg_shadow_regs #(
  parameter int unsigned NumChips     = 2,
  parameter int unsigned NumPhys      = 2,
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned RegDataWidth = 32,
  parameter type reg_req_t = hyperbus_pkg::reg_req_t,
  parameter type reg_rsp_t = hyperbus_pkg::reg_rsp_t,
  parameter type rule_t    = hyperbus_pkg::rule_t,
  parameter logic [RegDataWidth-1:0] RstChipBase  = 'h0,
  parameter logic [RegDataWidth-1:0] RstChipSpace = 'h0400_0000,
  parameter bit          AutoCommit   = 1'b0,
  parameter int unsigned MinFreqMhz   = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  reg_req_t                 reg_req_i,
  output reg_rsp_t                 reg_rsp_o,
  output hyperbus_pkg::hyper_cfg_t cfg_o,
  output rule_t                    chip_rules_o [NumChips],
  input  logic                     trans_active_i,
  output logic                     cfg_update_o
);

  localparam int unsigned NumCfg      = 12;
  localparam int unsigned NumRegs     = 13 + 2 * NumChips;
  localparam int unsigned IdxBits     = $clog2(NumRegs);
  localparam int unsigned StrbWidth   = RegDataWidth / 8;
  localparam int unsigned AddrLsb     = $clog2(StrbWidth);
  localparam int unsigned ChipIdxBits = (NumChips > 1) ? $clog2(NumChips) : 1;

  typedef logic [RegDataWidth-1:0] word_t;
  typedef enum logic [1:0] {IDLE, PEND, CHECK} state_e;

  function automatic word_t cfg_rst(input logic [3:0] sel);
    case (sel)
      4'd0, 4'd3: return word_t'(6);
      4'd2:       return word_t'(MinFreqMhz * 35 / 10);
      4'd6:       return word_t'(25);
      4'd8, 4'd9: return word_t'(NumPhys - 1);
      4'd10:      return word_t'(1);
      4'd11:      return word_t'(2);
      default:    return '0;
    endcase
  endfunction

  // Bits each cfg field actually owns; phy selection collapses to nothing
  // on single-PHY builds so those fields always read back as zero.
  function automatic word_t cfg_mask(input logic [3:0] sel);
    int unsigned w;
    case (sel)
      4'd0, 4'd3, 4'd4, 4'd5, 4'd10: w = 4;
      4'd2:       w = 16;
      4'd6:       w = 5;
      4'd11:      w = 3;
      4'd1, 4'd7: w = 1;
      4'd8, 4'd9: w = (NumPhys > 1) ? 1 : 0;
      default:    w = 0;
    endcase
    return word_t'((64'd1 << w) - 64'd1);
  endfunction

  state_e state_q, state_d;
  word_t  cfg_shadow_q   [NumCfg];
  word_t  cfg_active_q   [NumCfg];
  word_t  start_shadow_q [NumChips];
  word_t  end_shadow_q   [NumChips];
  word_t  start_active_q [NumChips];
  word_t  end_active_q   [NumChips];
  logic   dirty_q, err_q, lock_q, update_q;
  logic [7:0] cnt_q;

  logic [RegAddrWidth-1:0] addr;
  logic [IdxBits-1:0]      idx, chip_off;
  logic [3:0]              cfg_sel;
  logic [ChipIdxBits-1:0]  chip_sel;
  logic is_cfg, is_ctrl, is_chip, mapped, chip_is_end;
  logic wr_req, reg_wr, shadow_wr, ctrl_wr, commit_wr, commit_go, err_clr, lock_set;
  logic ranges_ok, check_pass, check_fail;
  word_t wdata, strb_mask, rd_word;

  assign addr     = reg_req_i.addr;
  assign idx      = addr[AddrLsb +: IdxBits];
  assign chip_off = idx - IdxBits'(13);
  assign cfg_sel  = idx[3:0];
  assign chip_sel = chip_off[ChipIdxBits:1];
  assign wdata    = reg_req_i.wdata;

  always_comb begin
    is_cfg      = idx < IdxBits'(NumCfg);
    is_ctrl     = idx == IdxBits'(12);
    is_chip     = (idx > IdxBits'(12)) && (idx < IdxBits'(NumRegs));
    mapped      = is_cfg || is_ctrl || is_chip;
    chip_is_end = chip_off[0];
    wr_req      = reg_req_i.valid && reg_req_i.write;
    reg_wr      = wr_req && (is_cfg || is_chip);
    shadow_wr   = reg_wr && !lock_q && (|reg_req_i.wstrb);
    ctrl_wr     = wr_req && is_ctrl && reg_req_i.wstrb[0];
    commit_wr   = ctrl_wr && wdata[0];
    commit_go   = commit_wr && !lock_q;
    err_clr     = ctrl_wr && wdata[2];
    lock_set    = ctrl_wr && wdata[3];
    strb_mask   = '0;
    for (int b = 0; b < StrbWidth; b++) begin
      strb_mask[8*b +: 8] = {8{reg_req_i.wstrb[b]}};
    end
  end

  // Reads always see the shadow copy; CTRL reflects live status.
  always_comb begin
    rd_word = '0;
    if (is_cfg) begin
      rd_word = cfg_shadow_q[cfg_sel];
    end else if (is_ctrl) begin
      rd_word = word_t'({cnt_q, 3'b000, state_q == PEND, lock_q, err_q, dirty_q, 1'b0});
    end else if (is_chip) begin
      rd_word = chip_is_end ? end_shadow_q[chip_sel] : start_shadow_q[chip_sel];
    end
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    if (reg_req_i.valid) begin
      reg_rsp_o.rdata = mapped ? rd_word : '0;
      reg_rsp_o.error = !mapped || (reg_wr && lock_q) || (commit_wr && lock_q);
    end
  end

  // End addresses are exclusive, so two ranges overlap iff each starts
  // before the other ends.
  always_comb begin
    ranges_ok = 1'b1;
    for (int i = 0; i < NumChips; i++) begin
      if (!(start_shadow_q[i] < end_shadow_q[i])) ranges_ok = 1'b0;
      for (int j = i + 1; j < NumChips; j++) begin
        if ((start_shadow_q[i] < end_shadow_q[j]) && (start_shadow_q[j] < end_shadow_q[i])) begin
          ranges_ok = 1'b0;
        end
      end
    end
    check_pass = (state_q == CHECK) && ranges_ok;
    check_fail = (state_q == CHECK) && !ranges_ok;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit_go || (AutoCommit && dirty_q)) state_d = PEND;
      PEND:    if (!trans_active_i) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCfg; i++) cfg_shadow_q[i] <= cfg_rst(4'(i));
      for (int i = 0; i < NumChips; i++) begin
        start_shadow_q[i] <= RstChipBase + word_t'(i) * RstChipSpace;
        end_shadow_q[i]   <= RstChipBase + word_t'(i + 1) * RstChipSpace;
      end
    end else if (shadow_wr) begin
      if (is_cfg) begin
        cfg_shadow_q[cfg_sel] <= ((cfg_shadow_q[cfg_sel] & ~strb_mask) | (wdata & strb_mask))
                                 & cfg_mask(cfg_sel);
      end else if (chip_is_end) begin
        end_shadow_q[chip_sel] <= (end_shadow_q[chip_sel] & ~strb_mask) | (wdata & strb_mask);
      end else begin
        start_shadow_q[chip_sel] <= (start_shadow_q[chip_sel] & ~strb_mask) | (wdata & strb_mask);
      end
    end
  end

  // The copy uses the shadow as it stood entering CHECK; a write landing in
  // the same cycle is left for the next commit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCfg; i++) cfg_active_q[i] <= cfg_rst(4'(i));
      for (int i = 0; i < NumChips; i++) begin
        start_active_q[i] <= RstChipBase + word_t'(i) * RstChipSpace;
        end_active_q[i]   <= RstChipBase + word_t'(i + 1) * RstChipSpace;
      end
    end else if (check_pass) begin
      cfg_active_q   <= cfg_shadow_q;
      start_active_q <= start_shadow_q;
      end_active_q   <= end_shadow_q;
    end
  end

  // A new shadow write keeps dirty set even if a commit finishes this cycle;
  // a failing check sets commit_err regardless of a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dirty_q  <= 1'b0;
      err_q    <= 1'b0;
      lock_q   <= 1'b0;
      update_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (shadow_wr)       dirty_q <= 1'b1;
      else if (check_pass) dirty_q <= 1'b0;
      if (check_fail)      err_q <= 1'b1;
      else if (err_clr)    err_q <= 1'b0;
      if (lock_set)        lock_q <= 1'b1;
      update_q <= check_pass;
      if (check_pass)      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign cfg_update_o = update_q;

  always_comb begin
    cfg_o                       = '0;
    cfg_o.t_latency_access      = cfg_active_q[0][3:0];
    cfg_o.en_latency_additional = cfg_active_q[1][0];
    cfg_o.t_burst_max           = cfg_active_q[2][15:0];
    cfg_o.t_read_write_recovery = cfg_active_q[3][3:0];
    cfg_o.t_rx_clk_delay        = cfg_active_q[4][3:0];
    cfg_o.t_tx_clk_delay        = cfg_active_q[5][3:0];
    cfg_o.address_mask_msb      = cfg_active_q[6][4:0];
    cfg_o.address_space         = cfg_active_q[7][0];
    cfg_o.phys_in_use           = cfg_active_q[8][0];
    cfg_o.which_phy             = cfg_active_q[9][0];
    cfg_o.t_csh_cycles          = cfg_active_q[10][3:0];
    cfg_o.rwds_sample           = cfg_active_q[11][2:0];
  end

  always_comb begin
    for (int i = 0; i < NumChips; i++) begin
      chip_rules_o[i]            = '0;
      chip_rules_o[i].idx        = 32'(i);
      chip_rules_o[i].start_addr = start_active_q[i];
      chip_rules_o[i].end_addr   = end_active_q[i];
    end
  end

endmodule

// File: tb/tb_hyperbus_cfg_shadow_regs.sv
// tb_hyperbus_cfg_shadow_regs
//   Directed bench for hyperbus_cfg_shadow_regs. Instance dut uses the default
//   parameters; instance dut_ac is built with AutoCommit=1 and NumPhys=1.
module tb_hyperbus_cfg_shadow_regs;

  import hyperbus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, trans0, trans1, upd0, upd1;
  reg_req_t   req0, req1;
  reg_rsp_t   rsp0, rsp1;
  hyper_cfg_t cfg0, cfg1;
  rule_t      rules0 [2];
  rule_t      rules1 [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] rst_exp [12] = '{32'd6, 32'd0, 32'd35, 32'd6, 32'd0, 32'd0,
                                32'd25, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2};

  hyperbus_cfg_shadow_regs dut (
    .clk_i(clk), .rst_i(rst0), .reg_req_i(req0), .reg_rsp_o(rsp0), .cfg_o(cfg0),
    .chip_rules_o(rules0), .trans_active_i(trans0), .cfg_update_o(upd0)
  );

  hyperbus_cfg_shadow_regs #(.AutoCommit(1'b1), .NumPhys(1)) dut_ac (
    .clk_i(clk), .rst_i(rst1), .reg_req_i(req1), .reg_rsp_o(rsp1), .cfg_o(cfg1),
    .chip_rules_o(rules1), .trans_active_i(trans1), .cfg_update_o(upd1)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one write for a cycle; returns error/ready seen during the request.
  task automatic reg_write(input bit which, input int unsigned widx, input logic [31:0] data,
                           input logic [3:0] strb, output logic err, output logic rdy);
    reg_req_t r;
    r.addr = 32'(widx << 2); r.write = 1'b1; r.wdata = data; r.wstrb = strb; r.valid = 1'b1;
    if (which) req1 = r; else req0 = r;
    #1;
    err = which ? rsp1.error : rsp0.error;
    rdy = which ? rsp1.ready : rsp0.ready;
    @(posedge clk);
    #1;
    req0 = '0;
    req1 = '0;
  endtask

  task automatic reg_read(input bit which, input int unsigned widx, output logic [31:0] data,
                          output logic err);
    reg_req_t r;
    r.addr = 32'(widx << 2); r.write = 1'b0; r.wdata = '0; r.wstrb = '0; r.valid = 1'b1;
    if (which) req1 = r; else req0 = r;
    #1;
    data = which ? rsp1.rdata : rsp0.rdata;
    err  = which ? rsp1.error : rsp0.error;
    req0 = '0;
    req1 = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic e, r;
    rst0 = 1'b1; rst1 = 1'b1; trans0 = 1'b0; trans1 = 1'b0;
    req0 = '0; req1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;

    // Reset state
    check_output("rst_update", upd0, 0);
    check_output("rst_cfg_lat", cfg0.t_latency_access, 6);
    check_output("rst_rule1_start", rules0[1].start_addr, 32'h0400_0000);
    check_output("rst_rule1_end", rules0[1].end_addr, 32'h0800_0000);
    check_output("rst_rule1_idx", rules0[1].idx, 1);
    for (int i = 0; i < 12; i++) begin
      reg_read(0, i, d, e);
      check_output($sformatf("rst_read_idx%0d", i), d, rst_exp[i]);
    end
    reg_read(0, 12, d, e);
    check_output("rst_ctrl", d, 0);
    check_output("rst_ctrl_err", e, 0);
    reg_read(0, 13, d, e); check_output("rst_chip0_start", d, 32'h0);
    reg_read(0, 14, d, e); check_output("rst_chip0_end", d, 32'h0400_0000);
    reg_read(0, 15, d, e); check_output("rst_chip1_start", d, 32'h0400_0000);
    reg_read(0, 16, d, e); check_output("rst_chip1_end", d, 32'h0800_0000);
    reg_read(0, 17, d, e);
    check_output("unmapped_err", e, 1);
    check_output("unmapped_rdata", d, 0);

    // Commit held off by an active transfer
    trans0 = 1'b1;
    reg_write(0, 0, 32'h9, 4'hf, e, r);
    check_output("w_idx0_ready", r, 1);
    check_output("w_idx0_err", e, 0);
    reg_write(0, 12, 32'h1, 4'hf, e, r);
    check_output("w_commit_ready", r, 1);
    reg_read(0, 12, d, e);
    check_output("pend_ctrl", d, 32'h12);
    @(posedge clk); #1;
    check_output("pend_cfg_lat", cfg0.t_latency_access, 6);
    trans0 = 1'b0;
    @(posedge clk); #1;
    check_output("check_cycle_update", upd0, 0);
    check_output("check_cycle_lat", cfg0.t_latency_access, 6);
    @(posedge clk); #1;
    check_output("commit_update", upd0, 1);
    check_output("commit_lat", cfg0.t_latency_access, 9);
    @(posedge clk); #1;
    check_output("commit_update_drop", upd0, 0);
    reg_read(0, 12, d, e);
    check_output("commit_ctrl", d, 32'h100);

    // Byte strobes
    reg_write(0, 0, 32'hf, 4'h0, e, r);
    reg_read(0, 0, d, e);  check_output("strb0_idx0", d, 9);
    reg_read(0, 12, d, e); check_output("strb0_ctrl", d, 32'h100);
    reg_write(0, 0, 32'h5, 4'h1, e, r);
    reg_read(0, 0, d, e);  check_output("strb1_idx0", d, 5);
    reg_read(0, 12, d, e); check_output("strb1_ctrl", d, 32'h102);

    // Overlapping ranges fail validation
    reg_write(0, 14, 32'h0500_0000, 4'hf, e, r);
    reg_write(0, 12, 32'h1, 4'hf, e, r);
    repeat (2) @(posedge clk); #1;
    reg_read(0, 12, d, e);
    check_output("fail_ctrl", d, 32'h106);
    check_output("fail_rule0_end", rules0[0].end_addr, 32'h0400_0000);
    check_output("fail_cfg_lat", cfg0.t_latency_access, 9);
    reg_write(0, 12, 32'h4, 4'hf, e, r);
    reg_read(0, 12, d, e);
    check_output("w1c_ctrl", d, 32'h102);
    reg_write(0, 14, 32'h0400_0000, 4'hf, e, r);
    reg_write(0, 12, 32'h1, 4'hf, e, r);
    repeat (2) @(posedge clk); #1;
    check_output("recommit_update", upd0, 1);
    check_output("recommit_lat", cfg0.t_latency_access, 5);
    reg_read(0, 12, d, e);
    check_output("recommit_ctrl", d, 32'h200);

    // Lock
    reg_write(0, 12, 32'h8, 4'hf, e, r);
    check_output("lock_set_err", e, 0);
    reg_read(0, 12, d, e); check_output("lock_ctrl", d, 32'h208);
    reg_write(0, 2, 32'h1234, 4'hf, e, r);
    check_output("lock_wr_err", e, 1);
    reg_read(0, 2, d, e);  check_output("lock_idx2", d, 32'h23);
    reg_write(0, 12, 32'h1, 4'hf, e, r);
    check_output("lock_commit_err", e, 1);
    @(posedge clk); #1;
    reg_read(0, 12, d, e); check_output("lock_ctrl_idle", d, 32'h208);
    check_output("lock_no_update", upd0, 0);

    // AutoCommit, single PHY
    reg_write(1, 9, 32'h1, 4'hf, e, r);
    reg_read(1, 9, d, e);  check_output("ac_which_phy", d, 0);
    reg_read(1, 8, d, e);  check_output("ac_phys_in_use", d, 0);
    reg_write(1, 3, 32'h3, 4'hf, e, r);
    @(posedge clk); #1;
    check_output("ac_check_update", upd1, 0);
    @(posedge clk); #1;
    check_output("ac_update", upd1, 1);
    check_output("ac_rrw", cfg1.t_read_write_recovery, 3);
    check_output("ac_cfg_which_phy", cfg1.which_phy, 0);
    @(posedge clk); #1;
    check_output("ac_update_drop", upd1, 0);
    reg_read(1, 12, d, e); check_output("ac_ctrl", d, 32'h100);

    // Reset while PEND
    trans1 = 1'b1;
    reg_write(1, 0, 32'ha, 4'hf, e, r);
    @(posedge clk); #1;
    reg_read(1, 12, d, e); check_output("ac_pend_ctrl", d, 32'h112);
    rst1 = 1'b1;
    #1;
    check_output("ac_rst_rrw", cfg1.t_read_write_recovery, 6);
    check_output("ac_rst_update", upd1, 0);
    @(posedge clk); #1;
    rst1 = 1'b0; trans1 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_output("ac_post_rst_update", upd1, 0);
    end
    reg_read(1, 12, d, e); check_output("ac_post_rst_ctrl", d, 0);
    reg_read(1, 0, d, e);  check_output("ac_post_rst_idx0", d, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
